// File: rtl/mips_multicycle_sequencer.sv
// mips_multicycle_sequencer
//   Multicycle control FSM for a MIPS datapath. Each instruction steps through
//   FETCH, DECODE, EXEC, MEM and WB as it needs them. Every cycle the FSM drives
//   the enables for PC, IR, the register file and the shared memory port.
//
//   Optional feature: define MIPS_SEQ_PERF_EN to add the saturating counters
//   cycle_cnt and instr_cnt.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   run                 run enable, sampled on every transition into FETCH
//   opcode, funct       IR fields; opcode is valid from DECODE onward
//   mem_ack             memory completed the current request
//   mem_req, mem_we     memory request (held until ack), write qualifier
//   iord                memory address select: 0 = PC, 1 = ALU result
//   ir_write, pc_write  IR / PC load enables
//   pc_src              0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs
//   branch              01 = beq, 10 = bne (datapath qualifies with zero)
//   reg_write, reg_dst  regfile write enable, dest select 0 = rt, 1 = rd, 2 = $31
//   mem_to_reg          write data select: 0 = ALU, 1 = memory
//   state_o             current state encoding
//   instr_done          one-cycle retirement pulse
//   err                 memory timeout; sticky until reset
//   cycle_cnt, instr_cnt  perf counters (MIPS_SEQ_PERF_EN only)
module mips_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] branch,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] state_o,
  output logic       instr_done,
  output logic       err
`ifdef MIPS_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

  if (MEM_TIMEOUT < 1) begin : g_bad_to
    $error("MEM_TIMEOUT must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cw
    $error("CNT_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23,
                         OP_SB    = 6'h28, OP_SH  = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t         state, state_d;
  logic [5:0]     op, fn;
  logic [TW-1:0]  tcnt;
  logic           tmo, is_store, is_mem;
  state_t         nxt_fetch;

  // This cycle is the MEM_TIMEOUT-th consecutive one without an ack.
  assign tmo       = (tcnt == TW'(MEM_TIMEOUT - 1));
  assign is_store  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  assign is_mem    = is_store || (op == OP_LW);
  // run gates every return to FETCH; the current instruction still retires.
  assign nxt_fetch = run ? FETCH : IDLE;
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      fn    <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_d;
      if (state == DECODE) begin
        op <= opcode;
        fn <= funct;
      end
      // Non-memory states hold the counter at zero, which clears it on entry.
      if ((state == FETCH || state == MEM) && !mem_ack) tcnt <= tcnt + 1'b1;
      else                                              tcnt <= '0;
    end
  end

  always_comb begin
    state_d    = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    branch     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      DECODE: begin
        // op/fn are still being latched, so decode from the live IR here.
        if (opcode == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          state_d    = nxt_fetch;
        end else if (opcode == OP_JAL) begin
          state_d = WB;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op == OP_BEQ || op == OP_BNE) begin
          branch     = (op == OP_BEQ) ? 2'b01 : 2'b10;
          pc_src     = 2'd1;
          instr_done = 1'b1;
          state_d    = nxt_fetch;
        end else if (op == OP_RTYPE && fn == FN_JR) begin
          pc_write   = 1'b1;
          pc_src     = 2'd3;
          instr_done = 1'b1;
          state_d    = nxt_fetch;
        end else if (is_mem) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            instr_done = 1'b1;
            state_d    = nxt_fetch;
          end else begin
            state_d = WB;
          end
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = nxt_fetch;
        if (op == OP_RTYPE) begin
          reg_dst = 2'd1;
        end else if (op == OP_JAL) begin
          reg_dst  = 2'd2;
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (op == OP_LW) begin
          mem_to_reg = 1'b1;
        end
      end
      ERR: err = 1'b1;
      default: state_d = IDLE;
    endcase
  end

`ifdef MIPS_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != IDLE && state != ERR && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done && instr_cnt != '1)                    instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Randomized bench for mips_multicycle_sequencer. The reference model expands
// each instruction into its expected per-cycle trace of states and strobes.
// Each trace entry also carries the mem_ack/run values to drive in that cycle.
module tb_mips_multicycle_sequencer;
  localparam int TO = 6;
  localparam int CW = 8;

  logic       clk = 1'b0, rst_n, run, mem_ack;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, mem_to_reg, instr_done, err;
  logic [1:0] pc_src, branch, reg_dst;
  logic [2:0] state_o;
`ifdef MIPS_SEQ_PERF_EN
  logic [CW-1:0] cycle_cnt, instr_cnt;
  int ecyc, einst;
`endif

  mips_multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state_o(state_o), .instr_done(instr_done), .err(err)
`ifdef MIPS_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src, branch,
                reg_write, reg_dst, mem_to_reg, instr_done, err};

  typedef struct packed {
    logic [17:0] o;   // expected {state, strobes}
    logic        ack; // mem_ack to drive this cycle
    logic        run; // run to drive this cycle
  } rec_t;

  rec_t q[$];
  int   vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rr();
    return 1'($urandom % 2);
  endfunction

  // st, req, we, iord, irw, pcw, pcs, br, rw, rd, m2r, done, err, ack, run
  function automatic rec_t mk(logic [2:0] st, logic rq, logic we, logic io, logic irw,
                              logic pcw, logic [1:0] pcs, logic [1:0] br, logic rw,
                              logic [1:0] rd, logic m2r, logic dn, logic er,
                              logic ak, logic rn);
    rec_t r;
    r.o   = {st, rq, we, io, irw, pcw, pcs, br, rw, rd, m2r, dn, er};
    r.ack = ak;
    r.run = rn;
    return r;
  endfunction

  function automatic rec_t idle_rec(logic rn);
    return mk(3'd0, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, rr(), rn);
  endfunction

  function automatic rec_t plain(logic [2:0] st);
    return mk(st, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, rr(), rr());
  endfunction

  // Expand one instruction. fd/md = cycles without ack in FETCH/MEM; a delay of
  // TO or more ends in ERR. rl = run value on the retiring cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fd,
                       input int md, input logic rl);
    logic st_ = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    logic mo  = st_ || (op == 6'h23);
    for (int i = 0; i < fd && i < TO; i++) q.push_back(mk(3'd1, 1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, 0, rr()));
    if (fd >= TO) begin
      repeat (3) q.push_back(mk(3'd7, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,1, rr(), rr()));
      return;
    end
    q.push_back(mk(3'd1, 1,0,0,1,1, 2'd0, 2'd0, 0, 2'd0, 0,0,0, 1, rr()));
    if (op == 6'h02) begin
      q.push_back(mk(3'd2, 0,0,0,0,1, 2'd2, 2'd0, 0, 2'd0, 0,1,0, rr(), rl));
    end else if (op == 6'h03) begin
      q.push_back(plain(3'd2));
      q.push_back(mk(3'd5, 0,0,0,0,1, 2'd2, 2'd0, 1, 2'd2, 0,1,0, rr(), rl));
    end else begin
      q.push_back(plain(3'd2));
      if (op == 6'h04 || op == 6'h05)
        q.push_back(mk(3'd3, 0,0,0,0,0, 2'd1, (op == 6'h04) ? 2'b01 : 2'b10, 0, 2'd0, 0,1,0, rr(), rl));
      else if (op == 6'h00 && fn == 6'h08)
        q.push_back(mk(3'd3, 0,0,0,0,1, 2'd3, 2'd0, 0, 2'd0, 0,1,0, rr(), rl));
      else if (mo) begin
        q.push_back(plain(3'd3));
        for (int i = 0; i < md && i < TO; i++) q.push_back(mk(3'd4, 1,st_,1,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, 0, rr()));
        if (md >= TO) begin
          repeat (3) q.push_back(mk(3'd7, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,1, rr(), rr()));
          return;
        end
        if (st_) q.push_back(mk(3'd4, 1,1,1,0,0, 2'd0, 2'd0, 0, 2'd0, 0,1,0, 1, rl));
        else begin
          q.push_back(mk(3'd4, 1,0,1,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, 1, rr()));
          q.push_back(mk(3'd5, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 1,1,0, rr(), rl));
        end
      end else begin
        q.push_back(plain(3'd3));
        q.push_back(mk(3'd5, 0,0,0,0,0, 2'd0, 2'd0, 1, (op == 6'h00) ? 2'd1 : 2'd0, 0,1,0, rr(), rl));
      end
    end
    if (!rl) q.push_back(idle_rec(1'b1));
  endtask

  // Apply up to n queued cycles; entered and left just after a rising edge.
  task automatic play(input string tag, input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      mem_ack = r.ack;
      run     = r.run;
      @(negedge clk);
      chk(tag, 32'(obs), 32'(r.o));
`ifdef MIPS_SEQ_PERF_EN
      chk({tag, "_ccnt"}, 32'(cycle_cnt), 32'(ecyc));
      chk({tag, "_icnt"}, 32'(instr_cnt), 32'(einst));
      if (r.o[17:15] != 3'd0 && r.o[17:15] != 3'd7) ecyc++;
      if (r.o[2]) einst++;
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                       input int md, input logic rl);
    opcode = op;
    funct  = fn;
    build(op, fn, fd, md, rl);
    play($sformatf("op%02h_fn%02h", op, fn), 1000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_async_state", 32'(state_o), 32'd0);
    chk("rst_async_outs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef MIPS_SEQ_PERF_EN
    ecyc  = 0;
    einst = 0;
`endif
  endtask

  logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h08, 6'h0d, 6'h0f, 6'h23, 6'h28, 6'h29, 6'h2B};

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = '0; funct = '0;
`ifdef MIPS_SEQ_PERF_EN
    ecyc = 0; einst = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    q.push_back(mk(3'd0, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 0,0,0, 1, 0));
    q.push_back(idle_rec(1'b1));
    play("reset_idle", 1000);

    instr(6'h00, 6'h20, 0, 0, 1);        // add
    instr(6'h23, 6'h00, 2, 2, 1);        // lw, late acks
    instr(6'h2B, 6'h00, 0, 1, 1);        // sw
    instr(6'h02, 6'h00, 0, 0, 1);        // j
    instr(6'h03, 6'h00, 0, 0, 1);        // jal
    instr(6'h00, 6'h08, 0, 0, 1);        // jr
    instr(6'h04, 6'h00, 0, 0, 1);        // beq
    instr(6'h05, 6'h00, 1, 0, 1);        // bne
    instr(6'h23, 6'h00, 1, 1, 0);        // lw with run dropped
    instr(6'h28, 6'h00, TO-1, TO-1, 1);  // longest legal waits

    for (int k = 0; k < 250; k++) begin
      logic [5:0] op, fn;
      int fd, md;
      op = ops[$urandom_range(0, 13)];
      fn = (k % 5 == 0) ? 6'h08 : 6'($urandom);
      fd = ($urandom % 4 == 0) ? int'($urandom_range(1, TO-1)) : 0;
      md = ($urandom % 4 == 0) ? int'($urandom_range(1, TO-1)) : 0;
      instr(op, fn, fd, md, ($urandom % 6) != 0);
    end

    // FETCH timeout, then reset recovery
    instr(6'h00, 6'h20, TO, 0, 1);
    do_reset();
    q.push_back(idle_rec(1'b1));
    play("post_err_idle", 1000);
    // MEM timeout on a store
    instr(6'h2B, 6'h00, 0, TO, 1);
    do_reset();
    q.push_back(idle_rec(1'b1));
    play("post_err2_idle", 1000);

    // Reset asserted while lw waits in MEM
    opcode = 6'h23;
    funct  = 6'h00;
    build(6'h23, 6'h00, 0, 3, 1);
    play("lw_pre_rst", 3);
    q.delete();
    mem_ack = 1'b0;
    #2;
    chk("mem_before_rst", 32'(state_o), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("mem_rst_state", 32'(state_o), 32'd0);
    chk("mem_rst_outs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    chk("mem_rst_no_regwr", 32'(reg_write), 32'd0);
    rst_n = 1'b1;
`ifdef MIPS_SEQ_PERF_EN
    ecyc = 0; einst = 0;
`endif
    q.push_back(idle_rec(1'b1));
    play("post_mem_rst", 1000);
    instr(6'h00, 6'h22, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
